// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants for the 16-to-4 request encoder
package enc_pkg;
  localparam int N  = 16;
  localparam int IW = 4;

  localparam logic          REQ_IDLE = 1'b1;
  localparam logic [N-1:0]  PEND_RST = 16'h0000;
  localparam logic [IW-1:0] PTR_RST  = 4'd15;
endpackage

// File: rtl/prio_enc16.sv
// rtl/prio_enc16.sv - combinational 16-way priority encoder with rotating start point
// Searches upward from start+1 with wrap; start=15 gives plain lowest-index-first.
module prio_enc16
  import enc_pkg::*;
(
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] index,
  output logic          found
);

  logic [IW-1:0] pos;

  always_comb begin
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int j = 0; j < N; j++) begin
      pos = start + IW'(j + 1);
      if (!found && pend[pos]) begin
        index = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc16to4_queue.sv
// rtl/enc16to4_queue.sv - captures active-low request lines and serves them as 4-bit indices
// Optional rotating priority when ENC16_ROUND_ROBIN_EN is defined.
module enc16to4_queue
  import enc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          En,
  input  logic [0:N-1]  F,
  output logic [IW-1:0] W,
  output logic          valid,
  input  logic          ready,
  output logic          pending
);

  logic [N-1:0]  pend;
  logic [N-1:0]  req;
  logic [N-1:0]  clr;
  logic [N-1:0]  pend_nxt;
  logic [IW-1:0] sel;
  logic [IW-1:0] start;
  logic          found;
  logic          load;

  prio_enc16 u_prio (
    .pend  (pend),
    .start (start),
    .index (sel),
    .found (found)
  );

  assign load = found && (!valid || ready);

  // A line captured in the same cycle its bit is served stays pending.
  always_comb begin
    req = '0;
    clr = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = En && (F[i] != REQ_IDLE);
    end
    if (load) begin
      clr[sel] = 1'b1;
    end
    pend_nxt = (pend & ~clr) | req;
  end

`ifdef ENC16_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PTR_RST;
    end else if (load) begin
      ptr <= sel;
    end
  end

  assign start = ptr;
`else
  assign start = PTR_RST;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pend    <= PEND_RST;
      W       <= '0;
      valid   <= 1'b0;
      pending <= 1'b0;
    end else begin
      pend    <= pend_nxt;
      pending <= |pend_nxt;
      if (load) begin
        W     <= sel;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enc16to4_queue.sv
// tb/tb_enc16to4_queue.sv - self-checking bench for enc16to4_queue
module tb_enc16to4_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        ready;
  logic [0:15] f;
  logic [3:0]  w;
  logic        valid;
  logic        pending;

  int n_pass  = 0;
  int n_total = 0;

  bit m_pend [16];
  bit m_valid;
  int m_w;
  int m_ptr;

  always #5 clk = ~clk;

  enc16to4_queue dut (
    .clk     (clk),
    .reset   (reset),
    .En      (en),
    .F       (f),
    .W       (w),
    .valid   (valid),
    .ready   (ready),
    .pending (pending)
  );

  // Next index in service order, -1 when nothing is pending.
  function automatic int pick();
    for (int j = 1; j <= 16; j++) begin
      int idx;
`ifdef ENC16_ROUND_ROBIN_EN
      idx = (m_ptr + j) % 16;
`else
      idx = j - 1;
`endif
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < 16; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_w     = 0;
      m_ptr   = 15;
    end else begin
      int s;
      s = pick();
      if (s >= 0 && (!m_valid || ready)) begin
        m_w       = s;
        m_valid   = 1'b1;
        m_pend[s] = 1'b0;
        m_ptr     = s;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      if (en) begin
        for (int i = 0; i < 16; i++) if (f[i] == 1'b0) m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"},   16'(valid),   16'(m_valid));
    check({tag, ".W"},       16'(w),       16'(m_w));
    check({tag, ".pending"}, 16'(pending), 16'(any_pend()));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    ready = 1'b1;
    f     = '1;
    tick("rst");
    tick("rst");
    check("rst.valid", 16'(valid), 16'd0);
    check("rst.W", 16'(w), 16'd0);
    check("rst.pending", 16'(pending), 16'd0);
    reset = 1'b0;

    repeat (5) begin
      tick("idle");
      check("idle.valid", 16'(valid), 16'd0);
    end

    f[5] = 1'b0;
    tick("single.cap");
    check("single.cap.valid", 16'(valid), 16'd0);
    f = '1;
    tick("single.load");
    check("single.valid", 16'(valid), 16'd1);
    check("single.W", 16'(w), 16'd5);
    tick("single.done");
    check("single.done.valid", 16'(valid), 16'd0);

    f[3] = 1'b0; f[9] = 1'b0; f[12] = 1'b0;
    tick("prio.cap");
    f = '1;
    repeat (4) tick("prio.drain");
    check("prio.end.valid", 16'(valid), 16'd0);

    f[7] = 1'b0;
    tick("bp.cap");
    f = '1;
    ready = 1'b0;
    repeat (4) begin
      tick("bp.hold");
      check("bp.W", 16'(w), 16'd7);
      check("bp.valid", 16'(valid), 16'd1);
      check("bp.pending", 16'(pending), 16'd0);
    end
    ready = 1'b1;
    tick("bp.accept");
    check("bp.accept.valid", 16'(valid), 16'd0);

    f[1] = 1'b0;
    tick("en.cap");
    en = 1'b0;
    f = '1;
    f[2] = 1'b0;
    ready = 1'b0;
    tick("en.load");
    check("en.W", 16'(w), 16'd1);
    ready = 1'b1;
    tick("en.accept");
    tick("en.gated");
    check("en.gated.valid", 16'(valid), 16'd0);
    check("en.gated.pending", 16'(pending), 16'd0);
    en = 1'b1;
    f = '1;

    f[4] = 1'b0;
    tick("soc.cap");
    repeat (4) begin
      tick("soc.stream");
      check("soc.W", 16'(w), 16'd4);
      check("soc.pending", 16'(pending), 16'd1);
    end
    reset = 1'b1;
    tick("soc.reset");
    check("soc.reset.valid", 16'(valid), 16'd0);
    check("soc.reset.pending", 16'(pending), 16'd0);
    reset = 1'b0;
    f = '1;
    tick("soc.after");

    repeat (400) begin
      reset = ($urandom_range(63) == 0);
      en    = ($urandom_range(7) != 0);
      ready = ($urandom_range(3) != 0);
      for (int i = 0; i < 16; i++) f[i] = ($urandom_range(7) != 0);
      tick("rand");
    end
    reset = 1'b0;
    f = '1;
    ready = 1'b1;
    repeat (20) tick("rand.drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
